// File: rtl/lib_fir_decim.sv
// lib_fir_decim: complex (I/Q) decimating FIR with runtime-loadable real coefficients.
// A single time-shared MAC per rail walks one tap per cycle. AXI4-Stream handshakes with
// backpressure on both the input and output sides.
module lib_fir_decim #(
   parameter int unsigned NUM_TAPS = 16,
   parameter int unsigned DECIM    = 4,
   parameter int unsigned DIN_BW   = 16,
   parameter int unsigned COEF_BW  = 16,
   parameter int unsigned DOUT_BW  = 32
) (
   input  logic                        s_axis_aclk,
   input  logic                        s_axis_areset,
   input  logic [DIN_BW-1:0]           s_axis_tdata_real,
   input  logic [DIN_BW-1:0]           s_axis_tdata_imag,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic                        s_axis_tready,
   output logic [DOUT_BW-1:0]          m_axis_tdata_real,
   output logic [DOUT_BW-1:0]          m_axis_tdata_imag,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
   input  logic                        coef_wr_en,
   input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
   input  logic [COEF_BW-1:0]          coef_wr_data,
   output logic                        coef_wr_ready
);

   localparam int unsigned AW   = $clog2(NUM_TAPS);
   localparam int unsigned PhW  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned PW   = DIN_BW + COEF_BW;
   localparam int unsigned AccW = PW + AW;
   localparam int unsigned SatW = (AccW > DOUT_BW) ? AccW : DOUT_BW;

   localparam logic [AW-1:0]  LastTap = AW'(NUM_TAPS - 1);
   localparam logic [AW:0]    TapsW   = (AW + 1)'(NUM_TAPS);
   localparam logic [PhW-1:0] LastPh  = PhW'(DECIM - 1);

   // Output limits expressed at the wider of accumulator/output width.
   localparam logic signed [SatW-1:0] SatMax =
      {{(SatW - DOUT_BW + 1){1'b0}}, {(DOUT_BW - 1){1'b1}}};
   localparam logic signed [SatW-1:0] SatMin = ~SatMax;

   // StAcc folds in the last registered product; StSat registers the saturated result.
   typedef enum logic [2:0] {StIn, StMac, StAcc, StSat, StOut} state_e;

   state_e state_q;

   logic signed [DIN_BW-1:0]  buf_re_q [NUM_TAPS];
   logic signed [DIN_BW-1:0]  buf_im_q [NUM_TAPS];
   logic signed [COEF_BW-1:0] coef_q   [NUM_TAPS];

   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [AW-1:0]  tap_q;
   logic [PhW-1:0] phase_q;
   logic           last_q;

   logic s_rdy_q;
   logic c_rdy_q;
   logic m_vld_q;
   logic m_last_q;
   logic [DOUT_BW-1:0] m_re_q;
   logic [DOUT_BW-1:0] m_im_q;

   logic signed [PW-1:0]   prod_re_q, prod_im_q;
   logic signed [PW-1:0]   prod_re_d, prod_im_d;
   logic                   prod_vld_q;
   logic signed [AccW-1:0] acc_re_q, acc_im_q;

   logic          in_acc;
   logic          trigger;
   logic [AW-1:0] wr_ptr_nxt;
   logic [AW-1:0] rd_ptr_dec;
   logic          coef_we;

   assign in_acc     = s_axis_tvalid && s_rdy_q;
   assign trigger    = (phase_q == LastPh) || s_axis_tlast;
   assign wr_ptr_nxt = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + 1'b1;
   // Taps walk backwards in time from the newest sample.
   assign rd_ptr_dec = (rd_ptr_q == '0) ? LastTap : rd_ptr_q - 1'b1;
   assign coef_we    = coef_wr_en && c_rdy_q && ({1'b0, coef_wr_addr} < TapsW);

   assign prod_re_d = PW'(buf_re_q[rd_ptr_q]) * PW'(coef_q[tap_q]);
   assign prod_im_d = PW'(buf_im_q[rd_ptr_q]) * PW'(coef_q[tap_q]);

   function automatic logic [DOUT_BW-1:0] saturate(input logic signed [AccW-1:0] a);
      logic signed [SatW-1:0] ext;
      ext = SatW'(a);
      if (ext > SatMax) return SatMax[DOUT_BW-1:0];
      if (ext < SatMin) return SatMin[DOUT_BW-1:0];
      return ext[DOUT_BW-1:0];
   endfunction

   // Sample history ring and coefficient store; both cleared only by reset.
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            buf_re_q[i] <= '0;
            buf_im_q[i] <= '0;
            coef_q[i]   <= '0;
         end
      end else begin
         if (in_acc) begin
            buf_re_q[wr_ptr_q] <= s_axis_tdata_real;
            buf_im_q[wr_ptr_q] <= s_axis_tdata_imag;
         end
         if (coef_we) begin
            coef_q[coef_wr_addr] <= coef_wr_data;
         end
      end
   end

   // Registered products, then accumulation one cycle later.
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         prod_vld_q <= 1'b0;
         prod_re_q  <= '0;
         prod_im_q  <= '0;
         acc_re_q   <= '0;
         acc_im_q   <= '0;
      end else begin
         prod_vld_q <= (state_q == StMac);
         if (state_q == StMac) begin
            prod_re_q <= prod_re_d;
            prod_im_q <= prod_im_d;
         end
         if (in_acc && trigger) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
         end else if (prod_vld_q) begin
            acc_re_q <= acc_re_q + AccW'(prod_re_q);
            acc_im_q <= acc_im_q + AccW'(prod_im_q);
         end
      end
   end

   // Control FSM: accept samples, run the taps, present the result until taken.
   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         state_q  <= StIn;
         s_rdy_q  <= 1'b1;
         c_rdy_q  <= 1'b1;
         m_vld_q  <= 1'b0;
         m_last_q <= 1'b0;
         m_re_q   <= '0;
         m_im_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         tap_q    <= '0;
         phase_q  <= '0;
         last_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIn: begin
               if (in_acc) begin
                  wr_ptr_q <= wr_ptr_nxt;
                  if (trigger) begin
                     phase_q  <= '0;
                     last_q   <= s_axis_tlast;
                     rd_ptr_q <= wr_ptr_q;
                     tap_q    <= '0;
                     s_rdy_q  <= 1'b0;
                     c_rdy_q  <= 1'b0;
                     state_q  <= StMac;
                  end else begin
                     phase_q <= phase_q + 1'b1;
                  end
               end
            end
            StMac: begin
               rd_ptr_q <= rd_ptr_dec;
               tap_q    <= tap_q + 1'b1;
               if (tap_q == LastTap) begin
                  state_q <= StAcc;
               end
            end
            StAcc: begin
               state_q <= StSat;
            end
            StSat: begin
               m_vld_q  <= 1'b1;
               m_re_q   <= saturate(acc_re_q);
               m_im_q   <= saturate(acc_im_q);
               m_last_q <= last_q;
               state_q  <= StOut;
            end
            StOut: begin
               if (m_axis_tready) begin
                  m_vld_q <= 1'b0;
                  s_rdy_q <= 1'b1;
                  c_rdy_q <= 1'b1;
                  state_q <= StIn;
               end
            end
            default: begin
               state_q <= StIn;
            end
         endcase
      end
   end

   assign s_axis_tready     = s_rdy_q;
   assign coef_wr_ready     = c_rdy_q;
   assign m_axis_tvalid     = m_vld_q;
   assign m_axis_tlast      = m_last_q;
   assign m_axis_tdata_real = m_re_q;
   assign m_axis_tdata_imag = m_im_q;

endmodule
